// File: rtl/nat_join_2_pkg.sv
// Shared control-fabric definitions for the natural split/join blocks:
// FSM state encoding, a small sizing helper and the delay-parameter range check.
`ifndef NAT_CTRL_PARAM_CHECK
`define NAT_CTRL_PARAM_CHECK(val, lbl) \
  if ((val) < 1) begin : lbl \
    $error("nat control delay parameter must be at least 1"); \
  end
`endif

package nat_join_2_pkg;

  localparam logic [1:0] S_COLLECT   = 2'd0;
  localparam logic [1:0] S_DRIVE     = 2'd1;
  localparam logic [1:0] S_WAIT_FREE = 2'd2;
  localparam logic [1:0] S_FREE_DLY  = 2'd3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nat_join_2.sv
// Two-way join: waits for a drive token from each upstream branch, drives the
// downstream stage, then fans the downstream free back to both branches.
module nat_join_2
  import nat_join_2_pkg::*;
#(
  parameter int DRIVE_DLY = 1,
  parameter int FREE_DLY  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_drive0,
  input  logic i_drive1,
  input  logic i_freeNext,
  output logic o_drive,
  output logic o_free0,
  output logic o_free1,
  output logic o_busy,
  output logic o_err
);

  localparam int CW = $clog2(max2(DRIVE_DLY, FREE_DLY) + 1);

  `NAT_CTRL_PARAM_CHECK(DRIVE_DLY, g_chk_drive_dly)
  `NAT_CTRL_PARAM_CHECK(FREE_DLY, g_chk_free_dly)

  logic [1:0]    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          pend0_r, pend0_s;
  logic          pend1_r, pend1_s;
  logic          cnt_zero_s;
  logic          drive_s, free_s, busy_s, err_s;

  assign cnt_zero_s = (cnt_r == '0);

  // State, counter, flags and all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_COLLECT;
      cnt_r   <= '0;
      pend0_r <= 1'b0;
      pend1_r <= 1'b0;
      o_drive <= 1'b0;
      o_free0 <= 1'b0;
      o_free1 <= 1'b0;
      o_busy  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pend0_r <= pend0_s;
      pend1_r <= pend1_s;
      o_drive <= drive_s;
      o_free0 <= free_s;
      o_free1 <= free_s;
      o_busy  <= busy_s;
      o_err   <= err_s;
    end
  end

  // Next state, shared down-counter and pending flags; a drive on an
  // already-set flag is simply not accepted.
  always_comb begin
    state_s = state_r;
    cnt_s   = '0;
    pend0_s = pend0_r | (i_drive0 & ~pend0_r);
    pend1_s = pend1_r | (i_drive1 & ~pend1_r);
    case (state_r)
      S_COLLECT: begin
        if (pend0_s && pend1_s) begin
          state_s = S_DRIVE;
          cnt_s   = CW'(DRIVE_DLY - 1);
        end else begin
          state_s = S_COLLECT;
        end
      end
      S_DRIVE: begin
        if (cnt_zero_s) begin
          state_s = S_WAIT_FREE;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      S_WAIT_FREE: begin
        if (i_freeNext) begin
          state_s = S_FREE_DLY;
          cnt_s   = CW'(FREE_DLY - 1);
        end else begin
          state_s = S_WAIT_FREE;
        end
      end
      S_FREE_DLY: begin
        if (cnt_zero_s) begin
          state_s = S_COLLECT;
          pend0_s = 1'b0;
          pend1_s = 1'b0;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      default: begin
        state_s = S_COLLECT;
        pend0_s = 1'b0;
        pend1_s = 1'b0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    drive_s = (state_r == S_DRIVE) && cnt_zero_s;
    free_s  = (state_r == S_FREE_DLY) && cnt_zero_s;
    busy_s  = (state_s != S_COLLECT) || pend0_s || pend1_s;
    err_s   = o_err
            | (i_drive0 & pend0_r)
            | (i_drive1 & pend1_r)
            | (i_freeNext & (state_r != S_WAIT_FREE));
  end

endmodule

// File: tb/tb_nat_join_2.sv
// Self-checking bench for nat_join_2: two instances (DRIVE_DLY/FREE_DLY = 1/2
// and 3/1) share stimulus and are compared against an event-time model.
module tb_nat_join_2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_drive0 = 1'b0, i_drive1 = 1'b0, i_freeNext = 1'b0;
  logic a_drive, a_free0, a_free1, a_busy, a_err;
  logic b_drive, b_free0, b_free1, b_busy, b_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  nat_join_2 #(.DRIVE_DLY(1), .FREE_DLY(2)) dut_a (
    .clk(clk), .rst(rst), .i_drive0(i_drive0), .i_drive1(i_drive1),
    .i_freeNext(i_freeNext), .o_drive(a_drive), .o_free0(a_free0),
    .o_free1(a_free1), .o_busy(a_busy), .o_err(a_err));

  nat_join_2 #(.DRIVE_DLY(3), .FREE_DLY(1)) dut_b (
    .clk(clk), .rst(rst), .i_drive0(i_drive0), .i_drive1(i_drive1),
    .i_freeNext(i_freeNext), .o_drive(b_drive), .o_free0(b_free0),
    .o_free1(b_free1), .o_busy(b_busy), .o_err(b_err));

  // Reference model: a transaction is described by the edge at which the join
  // completed and the edge at which the free was accepted.
  int dly_d[2] = '{1, 3};
  int dly_f[2] = '{2, 1};
  bit m_p0[2], m_p1[2], m_joined[2], m_freed[2], m_err[2];
  bit e_drv[2], e_fr[2], e_busy[2];
  int m_jedge[2], m_fedge[2], m_edge[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_p0[k] = 0; m_p1[k] = 0; m_joined[k] = 0; m_freed[k] = 0; m_err[k] = 0;
      e_drv[k] = 0; e_fr[k] = 0; e_busy[k] = 0;
      m_jedge[k] = 0; m_fedge[k] = 0; m_edge[k] = 0;
    end
  endfunction

  function automatic void model_edge(int k, bit d0, bit d1, bit f);
    int e;
    bit wait_free, clr, np0, np1;
    m_edge[k]++;
    e = m_edge[k];
    e_drv[k]  = m_joined[k] && (e == m_jedge[k] + dly_d[k]);
    wait_free = m_joined[k] && (e > m_jedge[k] + dly_d[k]) && !m_freed[k];
    clr       = m_freed[k] && (e == m_fedge[k] + dly_f[k]);
    e_fr[k]   = clr;
    np0 = m_p0[k];
    np1 = m_p1[k];
    if (d0) begin
      if (m_p0[k]) m_err[k] = 1; else np0 = 1;
    end
    if (d1) begin
      if (m_p1[k]) m_err[k] = 1; else np1 = 1;
    end
    if (f) begin
      if (wait_free) begin m_freed[k] = 1; m_fedge[k] = e; end
      else m_err[k] = 1;
    end
    if (clr) begin
      m_joined[k] = 0; m_freed[k] = 0; np0 = 0; np1 = 0;
    end else if (!m_joined[k] && np0 && np1) begin
      m_joined[k] = 1; m_jedge[k] = e;
    end
    m_p0[k] = np0;
    m_p1[k] = np1;
    e_busy[k] = m_joined[k] || np0 || np1;
  endfunction

  function automatic logic [9:0] exp_vec();
    return {e_drv[0], e_fr[0], e_fr[0], e_busy[0], m_err[0],
            e_drv[1], e_fr[1], e_fr[1], e_busy[1], m_err[1]};
  endfunction

  function automatic logic [9:0] act_vec();
    return {a_drive, a_free0, a_free1, a_busy, a_err,
            b_drive, b_free0, b_free1, b_busy, b_err};
  endfunction

  task automatic cyc(input bit d0, input bit d1, input bit f);
    i_drive0 = d0; i_drive1 = d1; i_freeNext = f;
    @(posedge clk);
    model_edge(0, d0, d1, f);
    model_edge(1, d0, d1, f);
    #1;
    i_drive0 = 1'b0; i_drive1 = 1'b0; i_freeNext = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_drive0 = 1'b0; i_drive1 = 1'b0; i_freeNext = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (act_vec() !== 10'b0) $display("FAIL reset_hold cyc=%0d act=%b exp=%b", i, act_vec(), 10'b0);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      cyc(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (act_vec() !== 10'b0) $display("FAIL reset_idle e=%0d act=%b exp=%b", e, act_vec(), 10'b0);
      else n_pass++;
    end
  endtask

  task automatic test_staggered();
    int drv_e = -1, fr_e = -1, busy_first = -1, busy_last = -1;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      cyc(e == 3, e == 6, e == 12);
      n_chk++;
      if (act_vec() !== exp_vec()) $display("FAIL staggered e=%0d act=%b exp=%b", e, act_vec(), exp_vec());
      else n_pass++;
      if (a_drive && drv_e < 0) drv_e = e;
      if (a_free0 && fr_e < 0) fr_e = e;
      if (a_busy && busy_first < 0) busy_first = e;
      if (a_busy) busy_last = e;
    end
    n_chk++;
    if (drv_e !== 7) $display("FAIL staggered_drive_edge act=%0d exp=7", drv_e); else n_pass++;
    n_chk++;
    if (fr_e !== 14) $display("FAIL staggered_free_edge act=%0d exp=14", fr_e); else n_pass++;
    n_chk++;
    if (busy_first !== 3 || busy_last !== 13)
      $display("FAIL staggered_busy act=%0d..%0d exp=3..13", busy_first, busy_last);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int a_e = -1, b_e = -1;
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      cyc(e == 5, e == 5, e == 10);
      n_chk++;
      if (act_vec() !== exp_vec()) $display("FAIL simultaneous e=%0d act=%b exp=%b", e, act_vec(), exp_vec());
      else n_pass++;
      if (a_drive && a_e < 0) a_e = e;
      if (b_drive && b_e < 0) b_e = e;
    end
    n_chk++;
    if (a_e !== 6 || b_e !== 8) $display("FAIL simultaneous_edges act=%0d/%0d exp=6/8", a_e, b_e);
    else n_pass++;
  endtask

  task automatic test_dup_drive();
    int err_e = -1, drv_e = -1, fr_e = -1;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      cyc(e == 3 || e == 4, e == 8, e == 11);
      n_chk++;
      if (act_vec() !== exp_vec()) $display("FAIL dup_drive e=%0d act=%b exp=%b", e, act_vec(), exp_vec());
      else n_pass++;
      if (a_err && err_e < 0) err_e = e;
      if (a_drive && drv_e < 0) drv_e = e;
      if (a_free0 && fr_e < 0) fr_e = e;
    end
    n_chk++;
    if (err_e !== 4 || drv_e !== 9 || fr_e !== 13 || a_err !== 1'b1)
      $display("FAIL dup_drive_timing act=err%0d drv%0d free%0d sticky%b exp=err4 drv9 free13 sticky1",
               err_e, drv_e, fr_e, a_err);
    else n_pass++;
  endtask

  task automatic test_free_in_collect();
    int err_e = -1, drv_e = -1, early_free = 0;
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      cyc(e == 5, e == 5, e == 2 || e == 9);
      n_chk++;
      if (act_vec() !== exp_vec()) $display("FAIL free_collect e=%0d act=%b exp=%b", e, act_vec(), exp_vec());
      else n_pass++;
      if (a_err && err_e < 0) err_e = e;
      if (a_drive && drv_e < 0) drv_e = e;
      if (e < 5 && (a_free0 || a_free1 || a_busy)) early_free++;
    end
    n_chk++;
    if (err_e !== 2 || drv_e !== 6 || early_free !== 0)
      $display("FAIL free_collect_effect act=err%0d drv%0d stray%0d exp=err2 drv6 stray0", err_e, drv_e, early_free);
    else n_pass++;
  endtask

  task automatic test_reset_mid_free();
    int stray = 0, drv_e = -1, fr_e = -1;
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      cyc(e == 2, e == 2, e == 7);
      n_chk++;
      if (act_vec() !== exp_vec()) $display("FAIL reset_mid_pre e=%0d act=%b exp=%b", e, act_vec(), exp_vec());
      else n_pass++;
    end
    rst = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (act_vec() !== 10'b0) $display("FAIL reset_mid_async act=%b exp=%b", act_vec(), 10'b0);
    else n_pass++;
    repeat (2) begin
      @(posedge clk); #1;
      if (act_vec() !== 10'b0) stray++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (act_vec() !== 10'b0) stray++;
    end
    n_chk++;
    if (stray !== 0) $display("FAIL reset_mid_stray act=%0d exp=0", stray); else n_pass++;
    model_reset();
    for (int e = 1; e <= 12; e++) begin
      cyc(e == 2, e == 2, e == 6);
      n_chk++;
      if (act_vec() !== exp_vec()) $display("FAIL reset_mid_post e=%0d act=%b exp=%b", e, act_vec(), exp_vec());
      else n_pass++;
      if (a_drive && drv_e < 0) drv_e = e;
      if (a_free0 && fr_e < 0) fr_e = e;
    end
    n_chk++;
    if (drv_e !== 3 || fr_e !== 8) $display("FAIL reset_mid_timing act=%0d/%0d exp=3/8", drv_e, fr_e);
    else n_pass++;
  endtask

  task automatic test_random();
    bit d0, d1, f;
    for (int blk = 0; blk < 15; blk++) begin
      do_reset();
      for (int e = 1; e <= 60; e++) begin
        d0 = ($urandom_range(0, 5) == 0);
        d1 = ($urandom_range(0, 5) == 0);
        f  = ($urandom_range(0, 7) == 0);
        cyc(d0, d1, f);
        n_chk++;
        if (act_vec() !== exp_vec())
          $display("FAIL random blk=%0d e=%0d act=%b exp=%b", blk, e, act_vec(), exp_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_staggered();
    test_simultaneous();
    test_dup_drive();
    test_free_in_collect();
    test_reset_mid_free();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
